// File: rtl/sticky_priority_arbiter_pkg.sv
// Shared constants for the sticky priority arbiter: selection mode encodings
// and the elaboration-time clog2 helper.
package sticky_priority_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sticky_priority_arbiter_pick.sv
// Combinational circular first-set search: lowest set bit at or after i_start,
// wrapping past N-1 to 0. With i_start = 0 it is a plain lowest-index encoder.
module priority_pick
    import sticky_priority_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int IDXW = 5
) (
    input  logic [N-1:0]    i_vec,
    input  logic [IDXW-1:0] i_start,
    output logic            o_any,
    output logic [IDXW-1:0] o_index,
    output logic [N-1:0]    o_onehot
);

    localparam int            PW   = clog2(2 * N);
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [2*N-1:0] w_dbl;
    logic [PW-1:0]  w_pos;
    logic [IDXW-1:0] w_idx;

    assign w_dbl = {i_vec, i_vec};

    // w_pos walks the doubled vector; w_idx tracks the same position modulo N
    always_comb begin
        o_any   = 1'b0;
        o_index = '0;
        w_pos   = '0;
        w_idx   = i_start;
        for (int k = 0; k < N; k++) begin
            w_pos = PW'(i_start) + PW'(k);
            if (!o_any && w_dbl[w_pos]) begin
                o_any   = 1'b1;
                o_index = w_idx;
            end
            w_idx = (w_idx == LAST) ? '0 : w_idx + IDXW'(1);
        end
    end

    assign o_onehot = o_any ? (N'(1) << o_index) : '0;

endmodule

// File: rtl/sticky_priority_arbiter.sv
// Sticky event arbiter: captures request pulses into a pending vector and
// presents one unmasked pending source at a time behind valid/ready.
module sticky_priority_arbiter
    import sticky_priority_arbiter_pkg::*;
#(
    parameter int N           = 32,
    parameter int IDXW        = 5,
    parameter int ROUND_ROBIN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic            clear_all,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_index,
    output logic [N-1:0]    out_onehot,
    output logic [N-1:0]    pending,
    output logic            overflow,
    input  logic            overflow_clr
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [N-1:0]    r_pending;
    logic            r_valid;
    logic [IDXW-1:0] r_index;
    logic [N-1:0]    r_onehot;
    logic            r_overflow;
    logic [IDXW-1:0] r_ptr;

    logic            w_pop;
    logic [N-1:0]    w_pop_bits;
    logic [N-1:0]    w_cand;
    logic [IDXW-1:0] w_next_ptr;
    logic [IDXW-1:0] w_start;
    logic            w_ovf_set;
    logic            w_any;
    logic [IDXW-1:0] w_pick_idx;
    logic [N-1:0]    w_pick_oh;

    // A flush cancels a same-cycle pop: nothing is consumed, the pointer resets
    assign w_pop      = r_valid & out_ready & ~clear_all;
    assign w_pop_bits = w_pop ? r_onehot : '0;
    assign w_cand     = r_pending & mask & ~w_pop_bits;
    assign w_next_ptr = (r_index == LAST) ? '0 : r_index + IDXW'(1);
    assign w_ovf_set  = |(req & r_pending & ~w_pop_bits);

    // The grant loaded in the pop cycle searches from just past the one leaving
    assign w_start = (ROUND_ROBIN == ARB_RR) ? (w_pop ? w_next_ptr : r_ptr) : '0;

    priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .i_vec    (w_cand),
        .i_start  (w_start),
        .o_any    (w_any),
        .o_index  (w_pick_idx),
        .o_onehot (w_pick_oh)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_index    <= '0;
            r_onehot   <= '0;
            r_overflow <= 1'b0;
            r_ptr      <= '0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end

            if (clear_all) begin
                r_pending <= req;
                r_valid   <= 1'b0;
                r_ptr     <= '0;
            end else begin
                r_pending <= (r_pending & ~w_pop_bits) | req;
                if (w_pop) begin
                    r_ptr <= w_next_ptr;
                end
                // Index and one-hot only move on a load with a winner
                if (!r_valid || w_pop) begin
                    if (w_any) begin
                        r_valid  <= 1'b1;
                        r_index  <= w_pick_idx;
                        r_onehot <= w_pick_oh;
                    end else begin
                        r_valid  <= 1'b0;
                    end
                end
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_index  = r_index;
    assign out_onehot = r_onehot;
    assign pending    = r_pending;
    assign overflow   = r_overflow;

endmodule

// File: doc/sticky_priority_arbiter.md
Name: sticky_priority_arbiter

Overview:
- Parametrised, registered successor to the combinational 32-bit priority encoder.
- Latches single-cycle event pulses into a sticky pending vector and selects one pending, unmasked source per grant, using fixed-priority or round-robin mode.
- Presents the winner's index and one-hot code behind a valid/ready handshake.
- Sits between the voice/envelope event sources and the sequencing logic that services them one at a time.

Parameters:
- N, 32, number of event sources (2..64)
- IDXW, 5, index width; must equal clog2(N)
- ROUND_ROBIN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last granted index

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N  event pulses; a bit high for one cycle sets the matching pending bit
- mask  in  N  1 = source eligible for selection; masked pending bits are kept, not dropped
- clear_all  in  1  synchronous flush of pending and output stage
- out_valid  out  1  a grant is presented
- out_ready  in  1  consumer accepts the grant
- out_index  out  IDXW  index of the granted source
- out_onehot  out  N  one-hot form of out_index
- pending  out  N  current pending vector (status)
- overflow  out  1  sticky: an event arrived on an already-pending source
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset state: pending=0, out_valid=0, out_index=0, out_onehot=0, overflow=0, round-robin pointer=0.
- pop = out_valid & out_ready.
- Pending update: pending_next = (pending & ~(pop ? out_onehot : 0)) | req.
  - A req on the bit being popped in the same cycle leaves that bit set; it counts as a new event.
- Candidates: cand = pending & mask & ~(pop ? out_onehot : 0). This is computed from registered pending.
  - Same-cycle req bits are not candidates.
- Output stage loads when (!out_valid | pop):
  - If cand != 0: out_valid<=1, and out_index/out_onehot take the selected bit.
  - If cand == 0: out_valid<=0, and out_index/out_onehot hold their previous values.
- Hold rule: while out_valid & !out_ready, out_index and out_onehot are stable. Mask or req changes do not alter a presented grant.
- Latency:
  - req at edge t gives pending at t+1 and out_valid at t+2 when idle.
  - Back-to-back pops give one grant per cycle.
- Fixed mode selection: lowest set index of cand.
- Round-robin selection:
  - Pick the first set bit of cand at index >= ptr, wrapping to 0.
  - On pop, ptr <= (out_index+1) mod N.
  - ptr is unchanged when there is no pop.
- The presented grant's pending bit remains set until popped, so it stays visible on the pending port.
- Overflow:
  - Sets when any req[i] & pending[i] and bit i is not popped that cycle.
  - overflow_clr clears it; a set in the same cycle wins.
- clear_all:
  - pending <= req (same-cycle events survive).
  - out_valid <= 0; ptr <= 0.
  - overflow is untouched.
  - clear_all overrides pop.
- Mask change: takes effect on the next output-stage load. A masked bit becoming unmasked is eligible in the next selection.
- N not a power of two: ptr wrap uses mod N. Indices >= N are never produced.

Decomposition:
- Shared include holds the clog2 constant function and the mode encodings (ARB_FIXED=0, ARB_RR=1).
- One combinational sub-module, priority_pick (N, IDXW).
  - Inputs: vector, start pointer.
  - Outputs: any, index, onehot.
  - Uses a doubled-vector search so one instance serves both modes (start=0 for fixed).

Test Plan:
- Fixed mode, N=32: req=0x0000_0090 for one cycle with out_ready=1 → grants index 4 then 7 on consecutive cycles, then out_valid=0; pending reads 0.
- Backpressure: req bits 2 and 9, out_ready=0 for 5 cycles → out_index=2 held stable, pending=0x204. Raise ready → 2 then 9.
- Round-robin: pending bits 1, 3 and 5 re-fired after each pop → grant order 1, 3, 5, 1, 3, …; ptr wraps at N.
- Mask: pending bits 0 and 6, mask=~1 → grant 6 only. Then set mask=all → grant 0. Bit 0 is never lost.
- Overflow and same-cycle cases: req[3] twice before any pop → overflow=1, single grant of 3. Also req[3] in the cycle 3 is popped → overflow stays 0 and a second grant of 3 follows.
- Reset and flush:
  - Assert reset mid-grant → all outputs 0 immediately.
  - clear_all with req=0x10 while a grant is presented → out_valid=0 next cycle, pending=0x10, then grant 4.
